// File: rtl/pc_fetch_ctrl_pkg.sv
// pc_fetch_ctrl_pkg
//   Shared definitions for the IF-stage fetch controller and the branch unit:
//   PC_SRC encodings (must match the branch unit), branch type codes, the
//   fetch FSM state type and the next-PC select codes used by pc_next_mux.
package pc_fetch_ctrl_pkg;

   // PC source select driven by the branch unit alongside B_TAKE
   localparam logic [1:0] PC_SRC_NORM  = 2'b00;
   localparam logic [1:0] PC_SRC_FW    = 2'b01;
   localparam logic [1:0] PC_SRC_DATAB = 2'b10;
   localparam logic [1:0] PC_SRC_RSVD  = 2'b11;  // treated as NORM

   // Branch type codes shared with the branch unit
   typedef enum logic [2:0] {
      BR_NONE = 3'd0,
      BR_JMP  = 3'd1,
      BR_JC   = 3'd2,
      BR_JZ   = 3'd3,
      BR_CALL = 3'd4,
      BR_RET  = 3'd5,
      BR_RTI  = 3'd6
   } br_type_e;

   typedef enum logic [1:0] {
      S_RESET  = 2'b00,
      S_RUN    = 2'b01,
      S_INTVEC = 2'b10
   } fetch_state_e;

   typedef enum logic [2:0] {
      NXT_HOLD  = 3'd0,
      NXT_INC   = 3'd1,
      NXT_FW    = 3'd2,
      NXT_DATAB = 3'd3,
      NXT_MEM   = 3'd4
   } pc_sel_e;

   // Only FW and DataB sources redirect; NORM and the reserved code fall through
   function automatic logic is_redirect(input logic b_take, input logic [1:0] pc_src);
      return b_take && ((pc_src == PC_SRC_FW) || (pc_src == PC_SRC_DATAB));
   endfunction

endpackage

// File: rtl/pc_fetch_ctrl_next_mux.sv
// pc_next_mux
//   Combinational next-PC selector.
//   sel_i       : next-PC source select
//   pc_i        : current PC (hold value)
//   inc_i       : PC + 1
//   fw_target_i : forwarded jump/call/branch target
//   data_b_i    : return address popped from memory
//   imem_data_i : vector word read from instruction memory
//   pc_next_o   : selected next PC
module pc_next_mux
   import pc_fetch_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = 8
) (
   input  pc_sel_e           sel_i,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic [ADDR_W-1:0] inc_i,
   input  logic [ADDR_W-1:0] fw_target_i,
   input  logic [ADDR_W-1:0] data_b_i,
   input  logic [ADDR_W-1:0] imem_data_i,
   output logic [ADDR_W-1:0] pc_next_o
);

   always_comb begin
      pc_next_o = pc_i;
      case (sel_i)
         NXT_HOLD:  pc_next_o = pc_i;
         NXT_INC:   pc_next_o = inc_i;
         NXT_FW:    pc_next_o = fw_target_i;
         NXT_DATAB: pc_next_o = data_b_i;
         NXT_MEM:   pc_next_o = imem_data_i;
         default:   pc_next_o = pc_i;
      endcase
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//   IF-stage program counter owner. Runs the reset-vector and interrupt-vector
//   load sequences, applies branch-unit redirects and flushes IF/ID on every
//   redirect or vector load.
//   clk, rst            : clock, synchronous active-high reset
//   b_take, pc_src      : branch decision from the EX-stage branch unit
//   fw_target, data_b   : redirect targets (forwarded target / popped return)
//   stall, intr         : hazard stall, external interrupt request
//   imem_data/imem_addr : instruction memory read port (combinational read)
//   pc_out, pc_plus1    : current PC and PC+1
//   fetch_valid         : fetch is meaningful (RUN only)
//   flush_if_id         : squash IF/ID this cycle
//   int_ret_pc, int_ack : saved PC at interrupt entry, vector-load pulse
module pc_fetch_ctrl
   import pc_fetch_ctrl_pkg::*;
#(
   parameter int unsigned       ADDR_W         = 8,
   parameter logic [ADDR_W-1:0] RESET_VEC_ADDR = ADDR_W'(0),
   parameter logic [ADDR_W-1:0] INT_VEC_ADDR   = ADDR_W'(1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              b_take,
   input  logic [1:0]        pc_src,
   input  logic [ADDR_W-1:0] fw_target,
   input  logic [ADDR_W-1:0] data_b,
   input  logic              stall,
   input  logic              intr,
   input  logic [ADDR_W-1:0] imem_data,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [ADDR_W-1:0] pc_out,
   output logic [ADDR_W-1:0] pc_plus1,
   output logic              fetch_valid,
   output logic              flush_if_id,
   output logic [ADDR_W-1:0] int_ret_pc,
   output logic              int_ack
);

   fetch_state_e      state_q;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] int_ret_q;
   logic              int_pend_q;
   logic              int_ack_q;
   logic              enter_int;
   pc_sel_e           sel;

   assign pc_plus1   = pc_q + ADDR_W'(1);
   assign pc_out     = pc_q;
   assign int_ret_pc = int_ret_q;
   assign int_ack    = int_ack_q;

   // Outputs are forced to their reset values while rst is held so the
   // pipeline sees a clean squash even before the first reset edge lands.
   always_comb begin
      sel         = NXT_HOLD;
      imem_addr   = RESET_VEC_ADDR;
      fetch_valid = 1'b0;
      flush_if_id = 1'b1;
      enter_int   = 1'b0;
      if (!rst) begin
         case (state_q)
            S_RESET: sel = NXT_MEM;
            S_RUN: begin
               imem_addr   = pc_q;
               fetch_valid = 1'b1;
               if (is_redirect(b_take, pc_src)) begin
                  sel = (pc_src == PC_SRC_FW) ? NXT_FW : NXT_DATAB;
               end else if (stall) begin
                  flush_if_id = 1'b0;
               end else if (int_pend_q) begin
                  enter_int = 1'b1;
               end else begin
                  sel         = NXT_INC;
                  flush_if_id = 1'b0;
               end
            end
            S_INTVEC: begin
               imem_addr = INT_VEC_ADDR;
               sel       = NXT_MEM;
            end
            default: ;
         endcase
      end
   end

   pc_next_mux #(.ADDR_W(ADDR_W)) u_next_mux (
      .sel_i       (sel),
      .pc_i        (pc_q),
      .inc_i       (pc_plus1),
      .fw_target_i (fw_target),
      .data_b_i    (data_b),
      .imem_data_i (imem_data),
      .pc_next_o   (pc_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_RESET;
         pc_q       <= '0;
         int_pend_q <= 1'b0;
         int_ret_q  <= '0;
         int_ack_q  <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         int_ack_q <= 1'b0;
         case (state_q)
            S_RESET: state_q <= S_RUN;
            S_RUN: begin
               if (enter_int) begin
                  state_q    <= S_INTVEC;
                  int_ret_q  <= pc_q;
                  // a request on the entry cycle re-arms rather than being lost
                  int_pend_q <= intr;
               end else begin
                  int_pend_q <= int_pend_q | intr;
               end
            end
            S_INTVEC: begin
               state_q    <= S_RUN;
               int_ack_q  <= 1'b1;
               int_pend_q <= int_pend_q | intr;
            end
            default: state_q <= S_RESET;
         endcase
      end
   end

endmodule
